// File: rtl/canny_pkg.sv
// Shared definitions for the Canny pipeline stages: pixel width, 3x3 Gaussian
// kernel weights and the window-stage FSM encoding.
package canny_pkg;

  localparam int PIXEL_W     = 8;
  localparam int SUM_W       = 12;
  localparam int KERNEL_TAPS = 9;

  // Row-major, top-left first; weights sum to 16.
  localparam logic [3:0] GAUSS_K [KERNEL_TAPS] = '{
    4'd1, 4'd2, 4'd1,
    4'd2, 4'd4, 4'd2,
    4'd1, 4'd2, 4'd1
  };

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/line_window_3x3.sv
// 2*WIDTH+2 pixel shift register exposing a 3x3 window; tap i sits at
// taps[i*PIXEL_W +: PIXEL_W], row-major from top-left, bottom-right is din itself.
module line_window_3x3
  import canny_pkg::*;
#(
  parameter int WIDTH = 1920
) (
  input  logic                         clock,
  input  logic                         shift_en,
  input  logic [PIXEL_W-1:0]           din,
  output logic [KERNEL_TAPS*PIXEL_W-1:0] taps
);

  localparam int DEPTH = 2*WIDTH + 2;

  // sr[j] holds pixel k-1-j relative to the pixel currently on din.
  logic [PIXEL_W-1:0] sr [DEPTH];

  always_ff @(posedge clock) begin
    if (shift_en) begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign taps = {din,             sr[0],       sr[1],
                 sr[WIDTH-1],     sr[WIDTH],   sr[WIDTH+1],
                 sr[2*WIDTH-1],   sr[2*WIDTH], sr[2*WIDTH+1]};

endmodule

// File: rtl/gaussian_blur_3x3.sv
// 3x3 Gaussian smoothing between FWFT greyscale FIFO and Sobel FIFO; output is
// combinational in the cycle the (WIDTH+2)-th pixel is popped, 1 pixel/clock.
module gaussian_blur_3x3
  import canny_pkg::*;
#(
  parameter int WIDTH  = 1920,
  parameter int HEIGHT = 1080
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_empty,
  output logic               in_rd_en,
  input  logic [PIXEL_W-1:0] in_dout,
  input  logic               out_full,
  output logic               out_wr_en,
  output logic [PIXEL_W-1:0] out_din
);

  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(NPIX);
  localparam int ROW_W = $clog2(HEIGHT);
  localparam int COL_W = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(NPIX - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(WIDTH - 1);

  state_t                         state, state_nxt;
  logic                           adv;
  logic [CNT_W-1:0]               in_cnt;
  logic [ROW_W-1:0]               out_row;
  logic [COL_W-1:0]               out_col;
  logic [PIXEL_W-1:0]             win_din;
  logic [KERNEL_TAPS*PIXEL_W-1:0] taps;
  logic [SUM_W-1:0]               sum;
  logic                           border;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    adv       = 1'b0;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    if (!reset) begin
      unique case (state)
        ST_FILL: begin
          adv      = ~in_empty & ~out_full;
          in_rd_en = adv;
          if (adv && in_cnt == FILL_LAST) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          adv       = ~in_empty & ~out_full;
          in_rd_en  = adv;
          out_wr_en = adv;
          if (adv && in_cnt == PIX_LAST) state_nxt = ST_FLUSH;
        end
        ST_FLUSH: begin
          adv       = ~out_full;
          out_wr_en = adv;
          if (adv && out_row == ROW_LAST && out_col == COL_LAST) state_nxt = ST_FILL;
        end
        default: state_nxt = ST_FILL;
      endcase
    end
  end

  // Centre counters wrap to zero on the final flush output, so the next frame starts clean.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_cnt  <= '0;
      out_row <= '0;
      out_col <= '0;
    end else if (adv) begin
      if (state != ST_FLUSH) begin
        in_cnt <= (in_cnt == PIX_LAST) ? '0 : in_cnt + 1'b1;
      end
      if (out_wr_en) begin
        if (out_col == COL_LAST) begin
          out_col <= '0;
          out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end
    end
  end

  assign win_din = (state == ST_FLUSH) ? '0 : in_dout;

  line_window_3x3 #(.WIDTH(WIDTH)) u_window (
    .clock    (clock),
    .shift_en (adv),
    .din      (win_din),
    .taps     (taps)
  );

  always_comb begin
    sum = '0;
    for (int i = 0; i < KERNEL_TAPS; i++) begin
      sum = sum + SUM_W'(taps[i*PIXEL_W +: PIXEL_W]) * SUM_W'(GAUSS_K[i]);
    end
  end

  assign border  = (out_row == '0) || (out_row == ROW_LAST) ||
                   (out_col == '0) || (out_col == COL_LAST);
  assign out_din = border ? taps[4*PIXEL_W +: PIXEL_W] : sum[SUM_W-1:4];

endmodule

// File: tb/tb_gaussian_blur_3x3.sv
// Randomised bench for gaussian_blur_3x3 on a 5x5 frame, checked against a
// per-frame arithmetic blur model plus literal expectations.
module tb_gaussian_blur_3x3;

  localparam int W = 5;
  localparam int H = 5;
  localparam int N = W * H;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_empty = 1'b1;
  logic       in_rd_en;
  logic [7:0] in_dout = 8'h00;
  logic       out_full = 1'b0;
  logic       out_wr_en;
  logic [7:0] out_din;

  always #5 clock = ~clock;

  gaussian_blur_3x3 #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .in_dout   (in_dout),
    .out_full  (out_full),
    .out_wr_en (out_wr_en),
    .out_din   (out_din)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] in_q[$];
  int         exp_q[$];
  int         got[$];
  int         img[N];
  bit         stall_en = 1'b0;
  int         pop_total = 0;
  int         out_total = 0;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Model: border pixels pass through, interior is the weighted 3x3 sum / 16.
  task automatic send_frame(input int npush);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int s;
        if (r == 0 || r == H-1 || c == 0 || c == W-1) begin
          exp_q.push_back(img[r*W + c]);
        end else begin
          s = 0;
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              s += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1) * img[(r+dr)*W + c + dc];
          exp_q.push_back(s / 16);
        end
      end
    end
    for (int i = 0; i < npush; i++) in_q.push_back(8'(img[i]));
  endtask

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(posedge clock);
      if (exp_q.size() == 0 && in_q.size() == 0) break;
    end
    check("drain_pending_outputs", exp_q.size(), 0);
    repeat (12) @(posedge clock);
  endtask

  task automatic random_img();
    for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
  endtask

  // Upstream FWFT FIFO, downstream FIFO and the per-cycle compare process.
  initial begin
    forever begin
      @(posedge clock); #1;
      in_empty = (in_q.size() == 0) || (stall_en && $urandom_range(0, 99) < 30);
      in_dout  = in_empty ? 8'h00 : in_q[0];
      out_full = stall_en && ($urandom_range(0, 99) < 30);
      @(negedge clock);
      if (reset) begin
        check("rd_en_in_reset", int'(in_rd_en), 0);
        check("wr_en_in_reset", int'(out_wr_en), 0);
      end else begin
        if (in_empty) check("rd_while_empty", int'(in_rd_en), 0);
        if (out_full) check("wr_while_full", int'(out_wr_en), 0);
        if (in_rd_en && !in_empty) begin
          check("pop_after_prev_frame_done", int'(out_total >= (pop_total / N) * N), 1);
          void'(in_q.pop_front());
          pop_total++;
        end
        if (out_wr_en) begin
          if (out_total % N == 0)
            check("first_out_pop_index", pop_total, (out_total / N) * N + W + 2);
          got.push_back(int'(out_din));
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output: got %0d expected none", out_din);
          end else begin
            check("out_din", int'(out_din), exp_q.pop_front());
          end
          out_total++;
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Flat frame
    got.delete();
    for (int i = 0; i < N; i++) img[i] = 100;
    send_frame(N);
    wait_drain(400);
    check("flat_count", got.size(), 25);
    for (int i = 0; i < got.size(); i++) check("flat_pix", got[i], 100);

    // Impulse of 160 at centre
    got.delete();
    for (int i = 0; i < N; i++) img[i] = 0;
    img[12] = 160;
    send_frame(N);
    wait_drain(400);
    check("imp_count", got.size(), 25);
    if (got.size() == 25) begin
      check("imp_centre", got[12], 40);
      check("imp_up",     got[7],  20);
      check("imp_down",   got[17], 20);
      check("imp_left",   got[11], 20);
      check("imp_right",  got[13], 20);
      check("imp_ul",     got[6],  10);
      check("imp_ur",     got[8],  10);
      check("imp_dl",     got[16], 10);
      check("imp_dr",     got[18], 10);
      check("imp_corner", got[0],  0);
    end

    // Ramp
    got.delete();
    for (int i = 0; i < N; i++) img[i] = i * 10;
    send_frame(N);
    wait_drain(400);
    check("ramp_count", got.size(), 25);
    if (got.size() == 25) begin
      check("ramp_11",     got[6],  60);
      check("ramp_first",  got[0],  0);
      check("ramp_border", got[9],  90);
      check("ramp_last",   got[24], 240);
    end

    // Random image with random stalls on both sides
    got.delete();
    stall_en = 1'b1;
    random_img();
    send_frame(N);
    wait_drain(3000);
    stall_en = 1'b0;
    check("stall_count", got.size(), 25);

    // Two back-to-back frames
    got.delete();
    random_img();
    send_frame(N);
    random_img();
    send_frame(N);
    wait_drain(800);
    check("b2b_count", got.size(), 50);

    // Reset after 12 pixels of a frame, then a fresh full frame
    random_img();
    send_frame(12);
    for (int c = 0; c < 200 && in_q.size() != 0; c++) @(posedge clock);
    check("partial_consumed", in_q.size(), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    in_q.delete();
    exp_q.delete();
    got.delete();
    pop_total = 0;
    out_total = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    random_img();
    send_frame(N);
    wait_drain(400);
    check("post_reset_count", got.size(), 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gaussian_blur_3x3.md
Name: gaussian_blur_3x3

Overview:
Second stage of the Canny pipeline. It sits directly downstream of grayscale_top and consumes its 8-bit greyscale pixel FIFO. Each interior pixel is smoothed with the 3x3 kernel [1 2 1; 2 4 2; 1 2 1]/16, and the result is pushed into an output FIFO that feeds the Sobel stage. The block emits exactly WIDTH*HEIGHT pixels per frame, in raster order.

Parameters:
WIDTH, 1920, pixels per line.
HEIGHT, 1080, lines per frame.

Ports:
clock  input  1  single clock; all logic is rising-edge.
reset  input  1  synchronous, active-high.
in_empty  input  1  input FIFO empty (first-word-fall-through FIFO).
in_rd_en  output  1  pops the input FIFO; in_dout is consumed in the same cycle.
in_dout  input  8  greyscale pixel; valid whenever in_empty=0.
out_full  input  1  output FIFO full.
out_wr_en  output  1  pushes out_din into the output FIFO this cycle.
out_din  output  8  blurred pixel.

Behaviour:
- Window storage
  - Shift register (or line-buffer RAM with identical behaviour) of 2*WIDTH+2 pixels.
  - The 3x3 window taps are rows k-2W-2..k-2W, k-W-2..k-W and k-2..k, where k is the pixel being shifted in.
  - The bottom-right tap is in_dout directly; it is not registered.
- Window centre is c = k-WIDTH-1.
- Counters:
  - in_cnt: 0..W*H-1, incoming pixel index.
  - out_row: 0..HEIGHT-1, centre row.
  - out_col: 0..WIDTH-1, centre column.
- FSM states: FILL, RUN, FLUSH. Reset enters FILL and zeroes all counters.
- FILL
  - adv = ~in_empty & ~out_full; in_rd_en = adv.
  - Each adv shifts in one pixel; out_wr_en = 0.
  - After WIDTH+1 pixels have been consumed, go to RUN.
- RUN
  - adv = ~in_empty & ~out_full; in_rd_en = adv.
  - out_wr_en = adv, so one output is produced per consumed pixel.
  - When the last pixel of the frame (in_cnt = W*H-1) is consumed, go to FLUSH.
- FLUSH
  - adv = ~out_full; in_rd_en = 0.
  - Each adv shifts in a 0 in place of in_dout and asserts out_wr_en.
  - After WIDTH+1 outputs, go to FILL with counters cleared, ready for the next frame.
- out_wr_en and out_din are combinational from the current state, the taps and in_dout.
  - out_full is therefore honoured in the same cycle; no data is ever lost.
  - out_wr_en is never high while out_full = 1.
- Arithmetic
  - Weighted sum is 12 bits unsigned (max 4080).
  - out_din = sum[11:4], truncated with no rounding.
- Border pixels (out_row = 0 or HEIGHT-1, or out_col = 0 or WIDTH-1): out_din = centre tap unmodified.
  - Wrapped or garbage taps at borders are ignored.
  - Every FLUSH output is a border pixel, so the zero fill never reaches an output.
- Stall behaviour
  - If in_empty=1 in FILL/RUN, or out_full=1 in any state, nothing shifts and no counter moves.
  - The state holds indefinitely.
- Latency: the first output appears in the cycle the (WIDTH+2)-th input pixel is consumed. Throughput is 1 pixel/clock when unstalled.
- Reset mid-frame: in the next cycle, in_rd_en = 0 and out_wr_en = 0, counters are 0 and the state is FILL. Shift contents are don't-care. Remaining upstream pixels are treated as the start of a new frame.
- Outputs during reset: in_rd_en = 0, out_wr_en = 0. out_din is don't-care but must not be X-propagating into the FIFO.

Decomposition:
- Shared package canny_pkg holds:
  - PIXEL_W = 8;
  - the kernel weights;
  - the FSM state encoding (FILL, RUN, FLUSH).
- The package is reused by the Sobel, NMS and hysteresis stages.
- One natural sub-module, line_window_3x3: the 2*WIDTH+2 shift register with its nine tap outputs and a shift enable. The Sobel stage reuses it unchanged.

Test Plan:
- WIDTH=5, HEIGHT=5, all pixels 100, no stalls -> 25 outputs, all 100. First out_wr_en occurs in the cycle of input #7.
- 5x5 zeros with a 160 impulse at (2,2) -> (2,2)=40; (1,2),(3,2),(2,1),(2,3)=20; (1,1),(1,3),(3,1),(3,3)=10; all others 0.
- 5x5 ramp, pixel value = index*10 -> border outputs equal their inputs; interior (1,1) = 60, i.e. sum 960 >> 4.
- Random in_empty/out_full toggling (30% each) on a 5x5 random image -> output sequence identical to the unstalled golden model. out_wr_en is never high while out_full = 1.
- Two back-to-back 5x5 frames -> exactly 50 outputs. The second frame's outputs contain no pixels from the first frame, and no input is popped during FLUSH.
- Reset asserted after 12 inputs, then a full frame is sent -> no output during reset. Exactly 25 correct outputs follow.
